timer_display_driver: RTL and testbench

Downstream display stage for the two-mode timer core. It takes the core's two 8-bit binary count bytes (MSB = minutes/hundreds, LSB = seconds/centiseconds). It converts each byte to two BCD digits with a sequential shift-add-3 engine. It then time-multiplexes the four digits onto a shared 7-segment bus with a decimal point between the byte pairs. When the core reports the stop condition, the whole display flashes.

---
 rtl/timer_display_pkg.sv | 38 +++
 rtl/seg7_decoder.sv | 30 +++
 rtl/timer_display_driver.sv | 151 +++++++++++++++
 tb/tb_timer_display_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_display_pkg.sv
// Shared types and constants for the timer display stage: converter states,
// digit count, 7-segment patterns and the BCD helper functions.
package timer_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS = 4;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [7:0] clamp99(input logic [7:0] b);
    return (b > 8'd99) ? 8'd99 : b;
  endfunction

  // Shift-add-3 correction applied to both BCD nibbles before each shift.
  function automatic logic [7:0] bcd_adjust(input logic [7:0] acc);
    logic [7:0] res;
    res[3:0] = (acc[3:0] >= 4'd5) ? acc[3:0] + 4'd3 : acc[3:0];
    res[7:4] = (acc[7:4] >= 4'd5) ? acc[7:4] + 4'd3 : acc[7:4];
    return res;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-high 7-segment pattern; the blank flag or a non-decimal
// code turns every segment off.
module seg7_decoder
  import timer_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/timer_display_driver.sv
// Converts the timer core's two binary bytes to BCD and multiplexes the four
// digits onto a shared 7-segment bus, flashing the display on the stop flag.
module timer_display_driver
  import timer_display_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int BLINK_LOG2 = 6,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lsb_bin,
  input  logic [7:0] msb_bin,
  input  logic       stop,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int   PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic INV   = (ACTIVE_LOW != 0);

  conv_state_t r_state;
  logic [15:0] r_last;
  logic [7:0]  r_msb_sh, r_lsb_sh, r_msb_acc, r_lsb_acc;
  logic [2:0]  r_iter;
  logic        r_busy;
  logic [3:0]  r_m_tens, r_m_ones, r_l_tens, r_l_ones;

  logic [PRE_W-1:0]      r_pre;
  logic [1:0]            r_idx;
  logic [BLINK_LOG2-1:0] r_blink;
  logic                  r_phase;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  logic [7:0]            w_msb_adj, w_lsb_adj;
  logic [3:0]            w_digit;
  logic                  w_blank;
  logic [6:0]            w_seg_pat;
  logic [NUM_DIGITS-1:0] w_onehot, w_an_act;

  assign w_msb_adj = bcd_adjust(r_msb_acc);
  assign w_lsb_adj = bcd_adjust(r_lsb_acc);

  // r_last holds the raw inputs so an out-of-range byte does not retrigger forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_last    <= '0;
      r_msb_sh  <= '0;
      r_lsb_sh  <= '0;
      r_msb_acc <= '0;
      r_lsb_acc <= '0;
      r_iter    <= '0;
      r_busy    <= 1'b0;
      r_m_tens  <= '0;
      r_m_ones  <= '0;
      r_l_tens  <= '0;
      r_l_ones  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ({msb_bin, lsb_bin} != r_last) begin
            r_last    <= {msb_bin, lsb_bin};
            r_msb_sh  <= clamp99(msb_bin);
            r_lsb_sh  <= clamp99(lsb_bin);
            r_msb_acc <= '0;
            r_lsb_acc <= '0;
            r_iter    <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_msb_acc <= {w_msb_adj[6:0], r_msb_sh[7]};
          r_lsb_acc <= {w_lsb_adj[6:0], r_lsb_sh[7]};
          r_msb_sh  <= {r_msb_sh[6:0], 1'b0};
          r_lsb_sh  <= {r_lsb_sh[6:0], 1'b0};
          r_iter    <= r_iter + 3'd1;
          if (r_iter == 3'd7) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_m_tens <= r_msb_acc[7:4];
          r_m_ones <= r_msb_acc[3:0];
          r_l_tens <= r_lsb_acc[7:4];
          r_l_ones <= r_lsb_acc[3:0];
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_digit = r_l_ones;
    w_blank = 1'b0;
    case (r_idx)
      2'd1: w_digit = r_l_tens;
      2'd2: w_digit = r_m_ones;
      2'd3: begin
        w_digit = r_m_tens;
        w_blank = (r_m_tens == 4'd0);
      end
      default: w_digit = r_l_ones;
    endcase
  end

  seg7_decoder u_dec (
    .i_bcd   (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg_pat)
  );

  assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
  assign w_an_act = (stop && !r_phase) ? '0 : w_onehot;

  // Outputs are registered from the current index, so they trail it by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_blink <= '0;
      r_phase <= 1'b0;
      r_seg   <= {7{INV}};
      r_dp    <= INV;
      r_an    <= {NUM_DIGITS{INV}};
    end else begin
      if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
      r_blink <= r_blink + BLINK_LOG2'(1);
      if (&r_blink) r_phase <= ~r_phase;
      r_seg <= w_seg_pat ^ {7{INV}};
      r_dp  <= (r_idx == 2'd2) ^ INV;
      r_an  <= w_an_act ^ {NUM_DIGITS{INV}};
    end
  end

  assign seg  = r_seg;
  assign dp   = r_dp;
  assign an   = r_an;
  assign busy = r_busy;

endmodule

// File: tb/tb_timer_display_driver.sv
// Self-checking bench for timer_display_driver: table of conversions with a
// scoreboard of expected digits, plus flash and reset-abort sequences.
module tb_timer_display_driver;

  localparam int SCAN_DIV   = 2;
  localparam int BLINK_LOG2 = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] lsb_bin, msb_bin;
  logic       stop;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected digits packed {m_tens, m_ones, l_tens, l_ones}; nibble F = blank.
  logic [15:0] sb_q[$];

  typedef struct {
    logic [7:0]  msb;
    logic [7:0]  lsb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  timer_display_driver #(
    .SCAN_DIV   (SCAN_DIV),
    .BLINK_LOG2 (BLINK_LOG2),
    .ACTIVE_LOW (1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .lsb_bin (lsb_bin),
    .msb_bin (msb_bin),
    .stop    (stop),
    .seg     (seg),
    .dp      (dp),
    .an      (an),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for busy, got busy=%0b expected toggle", name, busy);
  endtask

  task automatic wait_conv(input bit chk_len, input string name);
    int hi;
    bit ok;
    hi = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (busy) begin ok = 1; hi = 1; end
    end
    if (!ok) begin timeout_fail({name, "_rise"}); return; end
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (busy) hi++;
      else      ok = 1;
    end
    if (!ok) begin timeout_fail({name, "_fall"}); return; end
    if (chk_len) chk({name, "_busy_len"}, hi, 9);
  endtask

  // One full refresh with stop=0: every slot must be one-hot with the right digit.
  task automatic check_scan(input logic [15:0] exp, input string name);
    logic [3:0] act_an;
    int p;
    logic [3:0] nib;
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      @(negedge clk);
      act_an = ~an;
      p = -1;
      for (int b = 0; b < 4; b++) if (act_an == (4'b0001 << b)) p = b;
      if (p < 0) begin
        chk($sformatf("%s_an_onehot[%0d]", name, i), {28'd0, an}, 32'hE);
      end else begin
        nib = exp[p*4 +: 4];
        chk($sformatf("%s_digit%0d", name, p), {24'd0, dp, seg},
            {24'd0, ~(p == 2), ~pat(nib)});
      end
    end
  endtask

  task automatic pop_and_scan(input string name);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", name);
    end else begin
      e = sb_q.pop_front();
      check_scan(e, name);
    end
  endtask

  initial begin
    vecs[0] = '{8'd7,   8'd45,  16'hF745};
    vecs[1] = '{8'd99,  8'd99,  16'h9999};
    vecs[2] = '{8'd150, 8'd200, 16'h9999};
    vecs[3] = '{8'd0,   8'd0,   16'hF000};
    vecs[4] = '{8'd12,  8'd3,   16'h1203};
    vecs[5] = '{8'd100, 8'd100, 16'h9999};
    vecs[6] = '{8'd59,  8'd59,  16'h5959};
    vecs[7] = '{8'd10,  8'd99,  16'h1099};
    vecs[8] = '{8'd255, 8'd0,   16'h9900};
    vecs[9] = '{8'd1,   8'd0,   16'hF100};

    rst_n = 1'b0; stop = 1'b0; msb_bin = 8'd0; lsb_bin = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_an",   {28'd0, an},   32'hF);
    chk("rst_seg",  {25'd0, seg},  32'h7F);
    chk("rst_dp",   {31'd0, dp},   32'h1);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_an",  {28'd0, an},  32'hE);
    chk("first_seg", {25'd0, seg}, {25'd0, ~7'h3F});
    check_scan(16'hF000, "reset_digits");

    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      msb_bin = vecs[v].msb;
      lsb_bin = vecs[v].lsb;
      sb_q.push_back(vecs[v].exp);
      wait_conv(1'b1, $sformatf("vec%0d", v));
      pop_and_scan($sformatf("vec%0d", v));
    end

    // Changes during busy: the last stable value wins after a second conversion.
    @(negedge clk); msb_bin = 8'd0; lsb_bin = 8'd10;
    sb_q.push_back(16'hF012);
    @(negedge clk); lsb_bin = 8'd11;
    @(negedge clk); lsb_bin = 8'd12;
    wait_conv(1'b0, "chg_first");
    wait_conv(1'b1, "chg_second");
    pop_and_scan("chg");

    // Flash: phase 0 blanks, phase 1 scans; then continuous scan with stop=0.
    @(negedge clk); stop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int n, idx, ph;
      logic [3:0] e_an;
      @(negedge clk);
      n = cyc;
      idx = ((n - 1) / SCAN_DIV) % 4;
      ph = ((n - 1) >> BLINK_LOG2) & 1;
      e_an = (ph == 0) ? 4'hF : ~(4'b0001 << idx);
      chk($sformatf("flash_an[%0d]", i), {28'd0, an}, {28'd0, e_an});
    end
    stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int n, idx;
      @(negedge clk);
      n = cyc;
      idx = ((n - 1) / SCAN_DIV) % 4;
      chk($sformatf("noflash_an[%0d]", i), {28'd0, an}, {28'd0, ~(4'b0001 << idx)});
    end

    // Reset during a conversion discards digits; same input reconverts after release.
    @(negedge clk); msb_bin = 8'd23; lsb_bin = 8'd57;
    sb_q.push_back(16'h2357);
    wait_conv(1'b1, "pre_abort");
    pop_and_scan("pre_abort");
    @(negedge clk); msb_bin = 8'd31; lsb_bin = 8'd68;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_an",   {28'd0, an},   32'hF);
    chk("abort_seg",  {25'd0, seg},  32'h7F);
    chk("abort_dp",   {31'd0, dp},   32'h1);
    chk("abort_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("abort_first_an",  {28'd0, an},   32'hE);
    chk("abort_first_seg", {25'd0, seg},  {25'd0, ~7'h3F});
    chk("abort_reconv",    {31'd0, busy}, 32'h1);
    sb_q.push_back(16'h3168);
    wait_conv(1'b0, "reconv");
    pop_and_scan("reconv");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
